// File: rtl/single_stage_pipeline_reg.sv
// Single-stage registered valid/ready slice used as a timing break between producer and consumer.
// Define PIPE_BUBBLE_FILL_EN to let an empty stage accept a word while the consumer is stalled.
module single_stage_pipeline_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic             advance;

`ifdef PIPE_BUBBLE_FILL_EN
  // An empty stage may fill regardless of downstream, collapsing bubbles.
  assign in_ready = out_ready | ~out_valid_q;
`else
  assign in_ready = out_ready;
`endif

  assign advance = in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      out_valid_d = in_valid;
      // Data only moves with a valid word so idle in_data never reaches the output.
      if (in_valid) begin
        out_data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_single_stage_pipeline_reg.sv
// Directed self-checking bench for single_stage_pipeline_reg; default build unless PIPE_BUBBLE_FILL_EN is defined.
module tb_single_stage_pipeline_reg;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_cmp;
  int n_err;

  single_stage_pipeline_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn    = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_in_ready_lo", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("rst_in_ready_hi", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    check("rst_held_valid", {31'd0, out_valid}, 32'd0);

    // Basic transfer
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd43;
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'd43);
    in_valid = 1'b0;
    in_data  = 32'd77;
    tick();
    check("t1_pop_valid", {31'd0, out_valid}, 32'd0);
    check("t1_pop_data", out_data, 32'd43);

`ifndef PIPE_BUBBLE_FILL_EN
    // Backpressure on an empty stage
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd99;
    #1;
    check("t2_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    check("t2_hold_data", out_data, 32'd43);
    check("t2_hold_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("t2_in_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    check("t2_load_valid", {31'd0, out_valid}, 32'd1);
    check("t2_load_data", out_data, 32'd99);
`else
    // Bubble fill: empty stage loads while downstream is stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    #1;
    check("t6_in_ready_empty", {31'd0, in_ready}, 32'd1);
    tick();
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_data", out_data, 32'd5);
    check("t6_in_ready_full", {31'd0, in_ready}, 32'd0);
    in_data = 32'd6;
    tick();
    check("t6_hold_data", out_data, 32'd5);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    check("t6_drain_valid", {31'd0, out_valid}, 32'd0);
    check("t6_drain_data", out_data, 32'd5);
    out_ready = 1'b1;
`endif

    // Streaming
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      tick();
      check($sformatf("t3_data%0d", i), out_data, i);
      check($sformatf("t3_valid%0d", i), {31'd0, out_valid}, 32'd1);
    end

    // Stall while full
    in_data = 32'hA5A5A5A5;
    tick();
    check("t4_load", out_data, 32'hA5A5A5A5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = (i % 2 == 0) ? 32'h5A5A5A5A : 32'hFFFF0000;
      #1;
      check($sformatf("t4_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
      check($sformatf("t4_data%0d", i), out_data, 32'hA5A5A5A5);
      check($sformatf("t4_valid%0d", i), {31'd0, out_valid}, 32'd1);
    end

    // Async reset mid-stream
    out_ready = 1'b1;
    in_data   = 32'h12345678;
    tick();
    check("t5_pre", out_data, 32'h12345678);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, out_valid}, 32'd0);
    check("t5_async_data", out_data, 32'd0);
    resetn = 1'b1;
    #1;
    in_valid = 1'b1;
    in_data  = 32'd7;
    tick();
    check("t5_resume_data", out_data, 32'd7);
    check("t5_resume_valid", {31'd0, out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
